bar_rd_completer: RTL and testbench

- Target-side responder for host memory reads (MRd32/MRd64) hitting one BAR of the endpoint.
- Parses the request on the 64-bit TRN Rx local-link and reads one DW from a register file.
- Returns a CplD, or a UR Cpl, on the TRN Tx local-link.
- Shares Tx with the DMA write engine through a req/gnt arbiter handshake.

---
 rtl/bar_rd_completer.sv | 240 ++++++++++++++++++++++++
 tb/tb_bar_rd_completer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_rd_completer.sv
// bar_rd_completer: answers single-DW host memory reads on one BAR.
// Rx side parses MRd32/MRd64 headers; Tx side reads the register file
// and returns a CplD (len == 1) or a UR completion (any other length).
//
// state    | meaning
// RX_IDLE  | waiting for start of frame
// RX_ADDR  | header accepted, expecting the address beat
// RX_SKIP  | discarding the rest of an unwanted TLP
// TX_IDLE  | no completion in flight
// TX_READ  | register read issued, waiting out the read latency
// TX_ARB   | holding tx_req until granted with completion credits
// TX_Q0    | driving completion qword0 (SOF)
// TX_Q1    | driving completion qword1 (EOF)
module bar_rd_completer #(
  parameter int BAR_INDEX  = 0,
  parameter int REG_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              trn_clk,
  input  logic              trn_reset,
  input  logic              trn_lnk_up_n,
  input  logic [63:0]       trn_rd,
  input  logic [7:0]        trn_rrem_n,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic              trn_rsrc_dsc_n,
  input  logic              trn_rdst_rdy_n,
  input  logic [6:0]        trn_rbar_hit_n,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  input  logic              trn_tdst_rdy_n,
  input  logic [3:0]        trn_tbuf_av,
  input  logic [15:0]       cfg_completer_id,
  output logic              tx_req,
  input  logic              tx_gnt,
  output logic              reg_rd_en,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [31:0]       reg_rd_data,
  output logic              rd_dropped
);

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_SKIP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_READ, TX_ARB, TX_Q0, TX_Q1} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic        rx_beat, hdr_valid, tx_busy;
  logic        hdr_load, req_load, drop, rd_start;
  logic [31:0] addr_sel;

  logic        hdr_fmt64, hdr_len1;
  logic [2:0]  hdr_tc;
  logic [1:0]  hdr_attr;
  logic [15:0] hdr_req_id;
  logic [7:0]  hdr_tag;
  logic [3:0]  hdr_fbe;

  logic        req_pend, req_len1;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_fbe;
  logic [4:0]  req_addr_lo;
  logic [31:0] rd_data;
  logic [2:0]  rd_cnt;

  logic [11:0] bc;
  logic [1:0]  la_lo;
  logic [31:0] dw0, dw1, dw2, dw3;

  logic unused_bits;
  assign unused_bits = ^{trn_rrem_n, trn_rd, addr_sel, trn_tbuf_av[3], trn_tbuf_av[1:0]};

  assign rx_beat   = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign hdr_valid = (trn_rd[60:56] == 5'b00000) && !trn_rd[62] && !trn_rbar_hit_n[BAR_INDEX];
  assign addr_sel  = hdr_fmt64 ? trn_rd[31:0] : trn_rd[63:32];
  // A request finishing its address beat while the last Tx beat is being
  // accepted is taken, since the Tx FSM is idle from the next cycle on.
  assign tx_busy   = req_pend ||
                     ((tx_state != TX_IDLE) && !((tx_state == TX_Q1) && !trn_tdst_rdy_n));

  // State registers; link down clears both FSMs synchronously.
  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else if (trn_lnk_up_n) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // Rx next state: header decode, address-beat acceptance or drop.
  always_comb begin
    rx_next  = rx_state;
    hdr_load = 1'b0;
    req_load = 1'b0;
    drop     = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_beat && !trn_rsof_n) begin
        if (hdr_valid && trn_reof_n) begin
          rx_next  = RX_ADDR;
          hdr_load = 1'b1;
        end else if (trn_reof_n) begin
          rx_next = RX_SKIP;
        end
      end
      RX_ADDR: if (rx_beat) begin
        if (trn_rsrc_dsc_n) begin
          if (tx_busy) drop = 1'b1;
          else         req_load = 1'b1;
        end
        rx_next = trn_reof_n ? RX_SKIP : RX_IDLE;
      end
      RX_SKIP: if (rx_beat && !trn_reof_n) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // Tx next state: read, arbitrate, then two Tx beats.
  always_comb begin
    tx_next  = tx_state;
    rd_start = 1'b0;
    case (tx_state)
      TX_IDLE: if (req_pend) begin
        if (req_len1) begin
          tx_next  = TX_READ;
          rd_start = 1'b1;
        end else begin
          tx_next = TX_ARB;
        end
      end
      TX_READ: if (rd_cnt == 3'd0) tx_next = TX_ARB;
      TX_ARB:  if (tx_gnt && trn_tbuf_av[2]) tx_next = TX_Q0;
      TX_Q0:   if (!trn_tdst_rdy_n) tx_next = TX_Q1;
      TX_Q1:   if (!trn_tdst_rdy_n) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Header/request capture, read strobe, latency down-counter, drop pulse.
  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      hdr_fmt64 <= 1'b0; hdr_len1 <= 1'b0; hdr_tc <= '0; hdr_attr <= '0;
      hdr_req_id <= '0; hdr_tag <= '0; hdr_fbe <= '0;
      req_pend <= 1'b0; req_len1 <= 1'b0; req_tc <= '0; req_attr <= '0;
      req_id <= '0; req_tag <= '0; req_fbe <= '0; req_addr_lo <= '0;
      rd_data <= '0; rd_cnt <= '0;
      reg_rd_en <= 1'b0; reg_rd_addr <= '0; rd_dropped <= 1'b0;
    end else if (trn_lnk_up_n) begin
      req_pend    <= 1'b0;
      rd_cnt      <= '0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      rd_dropped  <= 1'b0;
    end else begin
      if (hdr_load) begin
        hdr_fmt64  <= trn_rd[61];
        hdr_len1   <= (trn_rd[41:32] == 10'd1);
        hdr_tc     <= trn_rd[54:52];
        hdr_attr   <= trn_rd[45:44];
        hdr_req_id <= trn_rd[31:16];
        hdr_tag    <= trn_rd[15:8];
        hdr_fbe    <= trn_rd[3:0];
      end
      if (req_load) begin
        req_pend    <= 1'b1;
        req_len1    <= hdr_len1;
        req_tc      <= hdr_tc;
        req_attr    <= hdr_attr;
        req_id      <= hdr_req_id;
        req_tag     <= hdr_tag;
        req_fbe     <= hdr_fbe;
        req_addr_lo <= addr_sel[6:2];
        reg_rd_addr <= addr_sel[REG_AW+1:2];
      end else if ((tx_state == TX_IDLE) && req_pend) begin
        req_pend <= 1'b0;
      end
      reg_rd_en  <= rd_start;
      rd_dropped <= drop;
      if (rd_start) rd_cnt <= 3'(RD_LATENCY);
      else if ((tx_state == TX_READ) && (rd_cnt != 3'd0)) rd_cnt <= rd_cnt - 3'd1;
      if ((tx_state == TX_READ) && (rd_cnt == 3'd0)) rd_data <= reg_rd_data;
    end
  end

  // Byte count and lower address derived from the first-DW byte enables.
  always_comb begin
    bc = 12'd1;
    casez (req_fbe)
      4'b1??1:                   bc = 12'd4;
      4'b01?1, 4'b1?10:          bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
      default:                   bc = 12'd1;
    endcase
    la_lo = 2'b00;
    casez (req_fbe)
      4'b???1: la_lo = 2'b00;
      4'b??10: la_lo = 2'b01;
      4'b?100: la_lo = 2'b10;
      4'b1000: la_lo = 2'b11;
      default: la_lo = 2'b00;
    endcase
  end

  // Completion header/payload words and Tx beat outputs.
  always_comb begin
    dw0 = {1'b0, (req_len1 ? 2'b10 : 2'b00), 5'b01010, 1'b0, req_tc, 4'b0000,
           2'b00, req_attr, 2'b00, (req_len1 ? 10'd1 : 10'd0)};
    dw1 = {cfg_completer_id, (req_len1 ? 3'b000 : 3'b001), 1'b0, (req_len1 ? bc : 12'd4)};
    dw2 = {req_id, req_tag, 1'b0, req_addr_lo, la_lo};
    dw3 = req_len1 ? {rd_data[7:0], rd_data[15:8], rd_data[23:16], rd_data[31:24]} : 32'h0;
    trn_td         = 64'h0;
    trn_trem_n     = 8'h00;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    tx_req         = (tx_state == TX_ARB) || (tx_state == TX_Q0) || (tx_state == TX_Q1);
    if (tx_state == TX_Q0) begin
      trn_td         = {dw0, dw1};
      trn_tsof_n     = 1'b0;
      trn_tsrc_rdy_n = 1'b0;
    end else if (tx_state == TX_Q1) begin
      trn_td         = {dw2, dw3};
      trn_trem_n     = req_len1 ? 8'h00 : 8'h0F;
      trn_teof_n     = 1'b0;
      trn_tsrc_rdy_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_bar_rd_completer.sv
// Directed bench for bar_rd_completer with a 1-cycle register model,
// a simple follow-the-request arbiter and a Tx beat recorder.
module tb_bar_rd_completer;

  logic        clk = 1'b0;
  logic        trn_reset;
  logic        trn_lnk_up_n;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic [15:0] cfg_completer_id;
  logic        tx_req, tx_gnt;
  logic        reg_rd_en;
  logic [9:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        rd_dropped;

  int checks = 0;
  int errors = 0;
  int nb = 0;
  int rd_en_cycles = 0;
  int drop_cycles = 0;
  int req_cycles = 0;
  logic [63:0] beat_td [0:63];
  logic [7:0]  beat_trem [0:63];
  logic [1:0]  beat_se [0:63];

  bar_rd_completer #(.BAR_INDEX(0), .REG_AW(10), .RD_LATENCY(1)) dut (
    .trn_clk(clk), .trn_reset(trn_reset), .trn_lnk_up_n(trn_lnk_up_n),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_tbuf_av(trn_tbuf_av), .cfg_completer_id(cfg_completer_id),
    .tx_req(tx_req), .tx_gnt(tx_gnt), .reg_rd_en(reg_rd_en),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .rd_dropped(rd_dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_value(input logic [9:0] a);
    case (a)
      10'd4:   return 32'h1234_5678;
      10'd9:   return 32'hAABB_CCDD;
      default: return {22'h0, a};
    endcase
  endfunction

  // Register file model: data valid the cycle after the strobe.
  always @(posedge clk) if (reg_rd_en) reg_rd_data <= reg_value(reg_rd_addr);

  // Arbiter model: grant follows request one cycle later.
  always @(posedge clk) tx_gnt <= trn_reset ? 1'b0 : tx_req;

  // Monitors: accepted Tx beats and strobe/pulse cycle counts.
  always @(posedge clk) begin
    if (!trn_reset && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      beat_td[nb]   <= trn_td;
      beat_trem[nb] <= trn_trem_n;
      beat_se[nb]   <= {!trn_tsof_n, !trn_teof_n};
      nb            <= nb + 1;
    end
    if (reg_rd_en)  rd_en_cycles <= rd_en_cycles + 1;
    if (rd_dropped) drop_cycles  <= drop_cycles + 1;
    if (tx_req)     req_cycles   <= req_cycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [1:0] fmt, input logic [9:0] len, input logic [31:0] addr,
                          input logic [3:0] fbe, input logic [15:0] rid, input logic [7:0] tag,
                          input logic [6:0] bar_n, input logic dsc_n);
    @(negedge clk);
    trn_rd = {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, len,
              rid, tag, 4'h0, fbe};
    trn_rsof_n = 1'b0; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b0;
    trn_rbar_hit_n = bar_n; trn_rsrc_dsc_n = 1'b1;
    @(negedge clk);
    trn_rd = fmt[0] ? {32'h0, addr} : {addr, 32'h0};
    trn_rsof_n = 1'b1; trn_reof_n = 1'b0; trn_rsrc_dsc_n = dsc_n;
    @(negedge clk);
    trn_rsrc_rdy_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rbar_hit_n = 7'h7F; trn_rd = 64'h0;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (nb < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(nb), 64'(target));
  endtask

  task automatic wait_out(input string tag, input logic want_req, input int budget);
    int n = 0;
    while (((want_req && !tx_req) || (!want_req && trn_tsrc_rdy_n)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(want_req ? tx_req : !trn_tsrc_rdy_n), 64'd1);
  endtask

  task automatic run_cpl(input string tag, input logic [1:0] fmt, input logic [9:0] len,
                         input logic [31:0] addr, input logic [3:0] fbe, input logic [15:0] rid,
                         input logic [7:0] tg, input logic [63:0] q0, input logic [63:0] q1,
                         input logic [7:0] trem1, input logic [9:0] exp_raddr);
    int base = nb;
    int en0 = rd_en_cycles;
    send_req(fmt, len, addr, fbe, rid, tg, 7'h7E, 1'b1);
    wait_beats({tag, "_beats"}, base + 2, 60);
    check({tag, "_q0"}, beat_td[base], q0);
    check({tag, "_q1"}, beat_td[base+1], q1);
    check({tag, "_trem"}, {beat_trem[base], beat_trem[base+1]}, {8'h00, trem1});
    check({tag, "_sofeof"}, {beat_se[base], beat_se[base+1]}, 4'b1001);
    check({tag, "_rden"}, 64'(rd_en_cycles - en0), (len == 10'd1) ? 64'd1 : 64'd0);
    if (len == 10'd1) check({tag, "_raddr"}, 64'(reg_rd_addr), 64'(exp_raddr));
  endtask

  initial begin
    trn_reset = 1'b1; trn_lnk_up_n = 1'b0; trn_rd = '0; trn_rrem_n = 8'h00;
    trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rdst_rdy_n = 1'b0; trn_rbar_hit_n = 7'h7F; trn_tdst_rdy_n = 1'b0;
    trn_tbuf_av = 4'hF; cfg_completer_id = 16'h0200; reg_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_req, reg_rd_en, rd_dropped}, 6'b111000);
    check("rst_td", trn_td, 64'h0);
    check("rst_trem_addr", {trn_trem_n, 6'h0, reg_rd_addr}, 24'h0);
    trn_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed completions: MRd32 full DW, MRd64 single byte, UR, 3-byte span.
    run_cpl("mrd32", 2'b00, 10'd1, 32'h10, 4'hF, 16'h0100, 8'h05,
            64'h4A000001_02000004, 64'h01000510_78563412, 8'h00, 10'd4);
    run_cpl("mrd64", 2'b01, 10'd1, 32'h24, 4'h4, 16'h0101, 8'h06,
            64'h4A000001_02000001, 64'h01010626_DDCCBBAA, 8'h00, 10'd9);
    run_cpl("ur", 2'b00, 10'd2, 32'h20, 4'hF, 16'h0100, 8'h07,
            64'h0A000000_02002004, 64'h01000720_00000000, 8'h0F, 10'd0);
    run_cpl("span3", 2'b00, 10'd1, 32'h08, 4'hA, 16'h0100, 8'h0C,
            64'h4A000001_02000003, 64'h01000C09_02000000, 8'h00, 10'd2);

    // Backpressure: credits withheld, then destination stalls on each beat.
    begin
      int base;
      base = nb;
      trn_tdst_rdy_n = 1'b1;
      trn_tbuf_av = 4'hB;
      send_req(2'b00, 10'd1, 32'h10, 4'hF, 16'h0200, 8'h08, 7'h7E, 1'b1);
      wait_out("bp_req", 1'b1, 30);
      repeat (5) @(negedge clk);
      check("bp_arb_hold", {tx_req, trn_tsrc_rdy_n}, 2'b11);
      trn_tbuf_av = 4'hF;
      wait_out("bp_q0", 1'b0, 10);
      for (int i = 0; i < 3; i++) begin
        check("bp_q0_hold", {trn_td, trn_tsof_n}, {64'h4A000001_02000004, 1'b0});
        @(negedge clk);
      end
      trn_tdst_rdy_n = 1'b0;
      @(negedge clk);
      trn_tdst_rdy_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check("bp_q1_hold", {trn_td, trn_teof_n, tx_req}, {64'h02000810_78563412, 1'b0, 1'b1});
        @(negedge clk);
      end
      trn_tdst_rdy_n = 1'b0;
      @(negedge clk);
      check("bp_beats", 64'(nb - base), 64'd2);
      check("bp_req_drop", 64'(tx_req), 64'd0);
    end

    // Second request while the first waits in arbitration is dropped.
    begin
      int base, d0;
      base = nb;
      d0 = drop_cycles;
      trn_tbuf_av = 4'hB;
      send_req(2'b00, 10'd1, 32'h10, 4'hF, 16'h0300, 8'h09, 7'h7E, 1'b1);
      wait_out("drop_req", 1'b1, 30);
      send_req(2'b00, 10'd1, 32'h24, 4'hF, 16'h0300, 8'h0A, 7'h7E, 1'b1);
      repeat (2) @(negedge clk);
      check("drop_pulse", 64'(drop_cycles - d0), 64'd1);
      trn_tbuf_av = 4'hF;
      wait_beats("drop_beats", base + 2, 40);
      repeat (20) @(negedge clk);
      check("drop_one_cpl", 64'(nb - base), 64'd2);
      check("drop_q1", beat_td[base+1], 64'h03000910_78563412);
    end

    // Ignored traffic: MWr on BAR0, MRd on BAR1, discontinued MRd.
    begin
      int base, e0, r0;
      base = nb; e0 = rd_en_cycles; r0 = req_cycles;
      send_req(2'b10, 10'd1, 32'h10, 4'hF, 16'h0500, 8'h01, 7'h7E, 1'b1);
      send_req(2'b00, 10'd1, 32'h10, 4'hF, 16'h0500, 8'h02, 7'h7D, 1'b1);
      send_req(2'b00, 10'd1, 32'h10, 4'hF, 16'h0500, 8'h03, 7'h7E, 1'b0);
      repeat (20) @(negedge clk);
      check("ign_tx", {32'(nb - base), 32'(req_cycles - r0)}, 64'h0);
      check("ign_rden", 64'(rd_en_cycles - e0), 64'd0);
    end

    // Reset while the EOF beat is stalled abandons the completion.
    begin
      int base;
      trn_tdst_rdy_n = 1'b1;
      send_req(2'b00, 10'd1, 32'h10, 4'hF, 16'h0600, 8'h04, 7'h7E, 1'b1);
      wait_out("rst_q0", 1'b0, 30);
      trn_tdst_rdy_n = 1'b0;
      @(negedge clk);
      trn_tdst_rdy_n = 1'b1;
      base = nb;
      check("rst_in_q1", 64'(trn_teof_n), 64'd0);
      trn_reset = 1'b1;
      @(negedge clk);
      check("rst_mid_ctl", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_req, reg_rd_en, rd_dropped}, 6'b111000);
      check("rst_mid_td", {trn_td, trn_trem_n, reg_rd_addr}, 82'h0);
      trn_reset = 1'b0;
      trn_tdst_rdy_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_eof", 64'(nb - base), 64'd0);
    end

    run_cpl("post_rst", 2'b00, 10'd1, 32'h24, 4'h8, 16'h0400, 8'h0B,
            64'h4A000001_02000001, 64'h04000B27_DDCCBBAA, 8'h00, 10'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
